// File: rtl/com_pkg.sv
// rtl/com_pkg.sv - shared bag codes, error causes and receiver state encoding for the com link
package com_pkg;

   localparam logic [3:0] BAG_INIT   = 4'h0;
   localparam logic [3:0] BAG_ACK    = 4'h1;
   localparam logic [3:0] BAG_NAK    = 4'h2;
   localparam logic [3:0] BAG_STALL  = 4'h3;
   localparam logic [3:0] BAG_DIDX   = 4'h5;
   localparam logic [3:0] BAG_DPARAM = 4'h6;
   localparam logic [3:0] BAG_DDIDX  = 4'h7;
   localparam logic [3:0] BAG_DLINK  = 4'h8;
   localparam logic [3:0] BAG_DTYPE  = 4'h9;
   localparam logic [3:0] BAG_DTEMP  = 4'hA;
   localparam logic [3:0] BAG_DHEAD  = 4'hC;
   localparam logic [3:0] BAG_DATA0  = 4'hD;
   localparam logic [3:0] BAG_DATA1  = 4'hE;

   localparam logic [1:0] ERR_CHECK   = 2'd0;
   localparam logic [1:0] ERR_TYPE    = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;
   localparam logic [1:0] ERR_OVERRUN = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_DONE    = 2'd2
   } rx_state_t;

   // Line encoding of a nibble: data in the high half, its complement in the low half.
   function automatic logic [7:0] bag_byte(input logic [3:0] value);
      return {value, ~value};
   endfunction

endpackage

// File: rtl/com_rx_chk.sv
// rtl/com_rx_chk.sv - combinational byte checker shared by header and payload decode
module com_rx_chk
   import com_pkg::*;
(
   input  logic [7:0] i_byte,
   output logic       o_check_ok,
   output logic [3:0] o_value,
   output logic       o_is_hs,
   output logic       o_is_param
);

   logic [3:0] w_value;

   assign w_value    = i_byte[7:4];
   assign o_value    = w_value;
   assign o_check_ok = (i_byte == bag_byte(w_value));
   assign o_is_hs    = (w_value == BAG_ACK) || (w_value == BAG_NAK) || (w_value == BAG_STALL);
   assign o_is_param = (w_value == BAG_DIDX) || (w_value == BAG_DPARAM) || (w_value == BAG_DDIDX);

endmodule

// File: rtl/com_rx.sv
// rtl/com_rx.sv - frames received com bytes into bags and presents them with the fs/fd handshake
module com_rx
   import com_pkg::*;
#(
   parameter int unsigned TIMEOUT = 1000
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_vld,
   input  logic [7:0] com_rxd,
   output logic       fs,
   input  logic       fd,
   output logic [3:0] btype,
   output logic [3:0] bdata,
   output logic       err,
   output logic [1:0] err_code
);

   // Counter is cleared on the cycle after the header, so expiry lands TIMEOUT cycles after it.
   localparam logic [15:0] LP_CNT_LAST = 16'(TIMEOUT - 1);

   rx_state_t   r_state;
   logic [15:0] r_cnt;
   logic [3:0]  r_ptype;
   logic        r_fs;
   logic [3:0]  r_btype;
   logic [3:0]  r_bdata;
   logic        r_err;
   logic [1:0]  r_err_code;

   logic        w_check_ok;
   logic [3:0]  w_value;
   logic        w_is_hs;
   logic        w_is_param;

   com_rx_chk u_chk (
      .i_byte     (com_rxd),
      .o_check_ok (w_check_ok),
      .o_value    (w_value),
      .o_is_hs    (w_is_hs),
      .o_is_param (w_is_param)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_ptype    <= '0;
         r_fs       <= 1'b0;
         r_btype    <= '0;
         r_bdata    <= '0;
         r_err      <= 1'b0;
         r_err_code <= ERR_CHECK;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (rx_vld) begin
                  if (!w_check_ok) begin
                     r_err      <= 1'b1;
                     r_err_code <= ERR_CHECK;
                  end else if (w_is_hs) begin
                     r_btype <= w_value;
                     r_bdata <= '0;
                     r_fs    <= 1'b1;
                     r_state <= ST_DONE;
                  end else if (w_is_param) begin
                     r_ptype <= w_value;
                     r_cnt   <= '0;
                     r_state <= ST_PAYLOAD;
                  end else if (w_value != BAG_INIT) begin
                     r_err      <= 1'b1;
                     r_err_code <= ERR_TYPE;
                  end
               end
            end
            ST_PAYLOAD: begin
               if (rx_vld) begin
                  if (w_check_ok) begin
                     r_btype <= r_ptype;
                     r_bdata <= w_value;
                     r_fs    <= 1'b1;
                     r_state <= ST_DONE;
                  end else begin
                     r_err      <= 1'b1;
                     r_err_code <= ERR_CHECK;
                     r_state    <= ST_IDLE;
                  end
               end else if (r_cnt == LP_CNT_LAST) begin
                  r_err      <= 1'b1;
                  r_err_code <= ERR_TIMEOUT;
                  r_state    <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            ST_DONE: begin
               // No buffering: anything arriving before the consumer releases is dropped.
               if (rx_vld) begin
                  r_err      <= 1'b1;
                  r_err_code <= ERR_OVERRUN;
               end
               if (fd) begin
                  r_fs    <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_fs    <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign fs       = r_fs;
   assign btype    = r_btype;
   assign bdata    = r_bdata;
   assign err      = r_err;
   assign err_code = r_err_code;

endmodule
